zigzag_buffer_ctrl: RTL and testbench
=====================================

# zigzag_buffer_ctrl

Sequencer for the 64×8-bit zigzag data buffer in the JPEG encoder pipeline. It accepts one 8×8 block as eight 64-bit rows over a valid/ready handshake from the quantizer, and drives the buffer's row-write strobes. Once the block is complete it fires the one-cycle zigzag enable, waits for the buffer's registered zigzag output, and then presents a valid/ready output handshake to the entropy coder. Rows of the next block may be loaded while the current zigzag result waits for downstream.

## Interface

Parameters:
- ZZ_LATENCY, 3: cycles from the cycle `buf_zigzag_enable` is high to the first cycle the buffer's `zigzag_pix_out` holds the new block. Legal range 2..15.
- CNT_WIDTH, 16: width of the completed-block counter.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream row valid.
- in_ready  out  1  row accepted when `in_valid && in_ready`.
- in_row_data  in  64  one row; byte [63:56] is column 0.
- buf_input_enable  out  1  buffer bulk-load enable; constant 0.
- buf_data_enable  out  1  buffer row-write strobe (registered).
- buf_matrix_row  out  8  row index for the write, 0..7 (registered).
- buf_row_data  out  64  row data for the write (registered).
- buf_zigzag_enable  out  1  one-cycle zigzag trigger (registered).
- out_valid  out  1  the buffer's `zigzag_pix_out` holds a complete, unconsumed block.
- out_ready  in  1  downstream accepts the block.
- blk_count  out  CNT_WIDTH  count of out handshakes; wraps.
- busy  out  1  high in any state other than FILL, or when `row_cnt != 0`.

## Operation

- State machine has five states: FILL, SETTLE, ZIG, WAIT, HOLD.
- `row_cnt` is a 4-bit counter with range 0..8. It increments on each input handshake.
- in_ready is combinational: `(state==FILL || state==HOLD) && row_cnt<8`.
- Row write on each input handshake, effective next cycle:
  - buf_data_enable = 1
  - buf_matrix_row = row_cnt (before increment)
  - buf_row_data = in_row_data
  - Otherwise buf_data_enable = 0; buf_matrix_row and buf_row_data hold their last values.
- FILL:
  - Go to SETTLE on the handshake that makes row_cnt reach 8.
- SETTLE:
  - Lasts one cycle so the 8th row write lands in the buffer.
  - Go to ZIG.
- ZIG:
  - Lasts one cycle and clears row_cnt to 0.
  - Go to WAIT with wait counter = ZZ_LATENCY-1.
  - buf_zigzag_enable is high exactly in the cycle after ZIG. This is the registered output of the ZIG state.
- WAIT:
  - Decrement the wait counter each cycle.
  - At 0, go to HOLD. out_valid rises with HOLD entry.
  - in_ready = 0 in WAIT, so no row is overwritten before the zigzag stage has sampled the matrix.
- HOLD:
  - out_valid = 1.
  - Rows of the next block are accepted and written.
  - On `out_valid && out_ready`, blk_count increments. Next state:
    - SETTLE if row_cnt==8 after this cycle's input handshake, if any.
    - FILL otherwise.
  - With row_cnt==8 and no out_ready, stay in HOLD with in_ready=0.
- out_valid never drops without a handshake.
- The block never issues a second buf_zigzag_enable while out_valid is high. This prevents the held output from being overwritten.
- Simultaneous 8th-row handshake and out handshake in the same HOLD cycle: both complete, next state is SETTLE.
- A handshake is ignored unless its valid and ready are both high. A valid raised without ready must be held by the source; the block does not require it.

## Timing

- Reset values, applied when reset_n=0 at a rising edge:
  - state = FILL, row_cnt = 0, wait counter = 0, blk_count = 0.
  - buf_data_enable = 0, buf_matrix_row = 0, buf_row_data = 0, buf_zigzag_enable = 0.
  - out_valid = 0, busy = 0, in_ready = 1 after reset.
- Reset mid-operation abandons the block; no partial output is flagged.
- Latency with back-to-back rows, taking the 8th handshake as cycle T:
  - Write strobe for row 7 in cycle T+1.
  - buf_zigzag_enable in cycle T+3.
  - out_valid from cycle T+3+ZZ_LATENCY.
- Throughput with out_ready tied high and in_valid tied high: one block per 8 + 3 + ZZ_LATENCY cycles, minus the rows overlapped in HOLD.
- in_ready is 0 for exactly ZZ_LATENCY+2 cycles per block (SETTLE, ZIG, WAIT) when downstream never stalls.

## Test plan

- Reset, then rows 0x0001..0x0008 at one per cycle, out_ready=1:
  - Strobes on rows 0..7 with matching data.
  - One buf_zigzag_enable pulse 2 cycles after the row-7 strobe.
  - out_valid for exactly 1 cycle at T+6.
  - blk_count = 1.
- in_valid toggling 1,0,1,0: only the 8 handshakes write; buf_matrix_row increments 0..7 without gaps.
- out_ready=0 for 20 cycles after out_valid while a second block is streamed:
  - 8 rows are written in HOLD, then in_ready = 0.
  - out_valid holds.
  - Raising out_ready gives SETTLE and a zigzag pulse 2 cycles later.
- 8th row and out_ready in the same cycle: both handshakes complete; next zigzag pulse in cycle +2; blk_count increments once.
- reset_n low for 1 cycle after row 4 is accepted: all outputs at reset values; the next block starts at row 0.
- blk_count preset near wrap by streaming 65536 blocks with CNT_WIDTH=16: wraps 0xFFFF→0x0000.

Source files
------------

// File: rtl/zigzag_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// zigzag_buffer_ctrl
//
// Sequencer for the 64x8-bit zigzag data buffer of the JPEG encoder. Accepts an
// 8x8 block as eight 64-bit rows from the quantizer, drives the buffer's
// row-write strobes, fires a one-cycle zigzag enable once the block is loaded,
// waits out the buffer's zigzag latency and then offers the result to the
// entropy coder. Rows of the next block may be loaded while the current
// result waits for downstream.
//
// Ports
//   clock              in   single clock, rising edge
//   reset_n            in   synchronous active-low reset
//   in_valid/in_ready  row handshake from the quantizer
//   in_row_data        in   64-bit row, byte [63:56] is column 0
//   buf_input_enable   out  buffer bulk-load enable, tied low
//   buf_data_enable    out  registered row-write strobe
//   buf_matrix_row     out  registered row index 0..7
//   buf_row_data       out  registered row data
//   buf_zigzag_enable  out  registered one-cycle zigzag trigger
//   out_valid/out_ready  block handshake to the entropy coder
//   blk_count          out  completed-block counter, wraps
//   busy               out  not idle (state != FILL or rows pending)
// -----------------------------------------------------------------------------
module zigzag_buffer_ctrl #(
   parameter int ZZ_LATENCY = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [63:0]          in_row_data,
   output logic                 buf_input_enable,
   output logic                 buf_data_enable,
   output logic [7:0]           buf_matrix_row,
   output logic [63:0]          buf_row_data,
   output logic                 buf_zigzag_enable,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CNT_WIDTH-1:0] blk_count,
   output logic                 busy
);

   typedef enum logic [2:0] {
      ST_FILL,
      ST_SETTLE,
      ST_ZIG,
      ST_WAIT,
      ST_HOLD
   } state_t;

   // WAIT lasts ZZ_LATENCY cycles: it counts from ZZ_LATENCY-1 down to 0.
   localparam logic [3:0] WAIT_INIT = 4'(ZZ_LATENCY - 1);

   state_t               state_q;
   logic [3:0]           row_cnt_q;
   logic [3:0]           row_cnt_d;
   logic [3:0]           wait_cnt_q;
   logic [CNT_WIDTH-1:0] blk_count_q;
   logic                 buf_data_enable_q;
   logic [7:0]           buf_matrix_row_q;
   logic [63:0]          buf_row_data_q;
   logic                 buf_zigzag_enable_q;
   logic                 in_hs;
   logic                 out_hs;

   // Rows are refused in SETTLE/ZIG/WAIT so the matrix is stable until the
   // zigzag stage has sampled it, and in HOLD once the next block is complete.
   assign in_ready  = ((state_q == ST_FILL) || (state_q == ST_HOLD)) && (row_cnt_q < 4'd8);
   assign out_valid = (state_q == ST_HOLD);
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;
   assign busy      = (state_q != ST_FILL) || (row_cnt_q != 4'd0);

   assign buf_input_enable  = 1'b0;
   assign buf_data_enable   = buf_data_enable_q;
   assign buf_matrix_row    = buf_matrix_row_q;
   assign buf_row_data      = buf_row_data_q;
   assign buf_zigzag_enable = buf_zigzag_enable_q;
   assign blk_count         = blk_count_q;

   // NOTE: every variable assigned in always_comb gets a value on every path;
   // a path that leaves it unassigned would infer a latch.
   always_comb begin
      row_cnt_d = row_cnt_q;
      if (in_hs) row_cnt_d = row_cnt_q + 4'd1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q             <= ST_FILL;
         row_cnt_q           <= 4'd0;
         wait_cnt_q          <= 4'd0;
         blk_count_q         <= '0;
         buf_data_enable_q   <= 1'b0;
         buf_matrix_row_q    <= 8'd0;
         buf_row_data_q      <= 64'd0;
         buf_zigzag_enable_q <= 1'b0;
      end else begin
         // Row write lands one cycle after its handshake; index and data hold
         // their last values between strobes.
         buf_data_enable_q <= in_hs;
         if (in_hs) begin
            buf_matrix_row_q <= {4'd0, row_cnt_q};
            buf_row_data_q   <= in_row_data;
         end

         buf_zigzag_enable_q <= (state_q == ST_ZIG);
         row_cnt_q           <= row_cnt_d;

         if (out_hs) blk_count_q <= blk_count_q + CNT_WIDTH'(1);

         case (state_q)
            ST_FILL: begin
               if (row_cnt_d == 4'd8) state_q <= ST_SETTLE;
            end
            // One cycle so the 8th row write reaches the buffer before the
            // zigzag stage samples it.
            ST_SETTLE: begin
               state_q <= ST_ZIG;
            end
            ST_ZIG: begin
               row_cnt_q  <= 4'd0;
               wait_cnt_q <= WAIT_INIT;
               state_q    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_cnt_q == 4'd0) state_q <= ST_HOLD;
               else                    wait_cnt_q <= wait_cnt_q - 4'd1;
            end
            // Leaving HOLD only on an out handshake guarantees no second
            // zigzag pulse can overwrite a result that is still offered.
            ST_HOLD: begin
               if (out_hs) state_q <= (row_cnt_d == 4'd8) ? ST_SETTLE : ST_FILL;
            end
            default: begin
               state_q <= ST_FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zigzag_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for zigzag_buffer_ctrl (ZZ_LATENCY = 3). A second instance
// with a 3-bit block counter shares every input so counter wrap is reachable
// in a short run.
// -----------------------------------------------------------------------------
module tb_zigzag_buffer_ctrl;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_row_data = 64'd0;
   logic        buf_input_enable;
   logic        buf_data_enable;
   logic [7:0]  buf_matrix_row;
   logic [63:0] buf_row_data;
   logic        buf_zigzag_enable;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] blk_count;
   logic        busy;

   logic        w_in_ready;
   logic        w_buf_input_enable;
   logic        w_buf_data_enable;
   logic [7:0]  w_buf_matrix_row;
   logic [63:0] w_buf_row_data;
   logic        w_buf_zigzag_enable;
   logic        w_out_valid;
   logic [2:0]  w_blk_count;
   logic        w_busy;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_blk = 16'd0;

   always #5 clock = ~clock;

   zigzag_buffer_ctrl #(.ZZ_LATENCY(3), .CNT_WIDTH(16)) u_dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_row_data(in_row_data), .buf_input_enable(buf_input_enable),
      .buf_data_enable(buf_data_enable), .buf_matrix_row(buf_matrix_row),
      .buf_row_data(buf_row_data), .buf_zigzag_enable(buf_zigzag_enable),
      .out_valid(out_valid), .out_ready(out_ready), .blk_count(blk_count), .busy(busy)
   );

   zigzag_buffer_ctrl #(.ZZ_LATENCY(3), .CNT_WIDTH(3)) u_dut_w (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_row_data(in_row_data), .buf_input_enable(w_buf_input_enable),
      .buf_data_enable(w_buf_data_enable), .buf_matrix_row(w_buf_matrix_row),
      .buf_row_data(w_buf_row_data), .buf_zigzag_enable(w_buf_zigzag_enable),
      .out_valid(w_out_valid), .out_ready(out_ready), .blk_count(w_blk_count), .busy(w_busy)
   );

   // Advance one clock; inputs change and outputs are observed 1 ns after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Offer one row, wait (bounded) for in_ready, and check the resulting write.
   task automatic send_row(input logic [63:0] d, input logic [7:0] exp_row);
      int n;
      n = 0;
      in_valid    = 1'b1;
      in_row_data = d;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL send_row_timeout in_ready=%b required=1", in_ready);
         in_valid = 1'b0;
         return;
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (buf_data_enable !== 1'b1 || buf_matrix_row !== exp_row || buf_row_data !== d) begin
         failures++;
         $display("FAIL row_write en=%b row=%0d data=%h required en=1 row=%0d data=%h",
                  buf_data_enable, buf_matrix_row, buf_row_data, exp_row, d);
      end
   endtask

   task automatic send_block(input logic [63:0] base);
      for (int r = 0; r < 8; r++) send_row(base + 64'(r), 8'(r));
   endtask

   task automatic wait_out_valid();
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL out_valid_timeout out_valid=%b required=1", out_valid);
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_blk++;
      checks++;
      if (out_valid !== 1'b0 || blk_count !== exp_blk) begin
         failures++;
         $display("FAIL consume out_valid=%b blk_count=%0d required out_valid=0 blk_count=%0d",
                  out_valid, blk_count, exp_blk);
      end
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_status in_ready=%b out_valid=%b busy=%b required 1 0 0",
                  name, in_ready, out_valid, busy);
      end
      checks++;
      if (buf_data_enable !== 1'b0 || buf_matrix_row !== 8'd0 || buf_row_data !== 64'd0) begin
         failures++;
         $display("FAIL %s_buf en=%b row=%0d data=%h required 0 0 0",
                  name, buf_data_enable, buf_matrix_row, buf_row_data);
      end
      checks++;
      if (buf_zigzag_enable !== 1'b0 || buf_input_enable !== 1'b0 || blk_count !== 16'd0) begin
         failures++;
         $display("FAIL %s_misc zz=%b input_en=%b blk_count=%0d required 0 0 0",
                  name, buf_zigzag_enable, buf_input_enable, blk_count);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      check_reset_values("reset");
      exp_blk = 16'd0;
   endtask

   // Back-to-back block with out_ready high: T is the 8th handshake cycle,
   // the first observation after the last send_row is T+1.
   task automatic test_single_block();
      out_ready = 1'b1;
      for (int r = 0; r < 8; r++) send_row(64'(r + 1), 8'(r));
      for (int c = 1; c <= 7; c++) begin
         if (c > 1) tick();
         checks++;
         if (buf_zigzag_enable !== (c == 3) || out_valid !== (c == 6) || in_ready !== (c >= 6)) begin
            failures++;
            $display("FAIL latency_T+%0d zz=%b out_valid=%b in_ready=%b required %b %b %b",
                     c, buf_zigzag_enable, out_valid, in_ready, c == 3, c == 6, c >= 6);
         end
      end
      exp_blk++;
      out_ready = 1'b0;
      checks++;
      if (blk_count !== exp_blk || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_block_end blk_count=%0d busy=%b required %0d 0",
                  blk_count, busy, exp_blk);
      end
   endtask

   task automatic test_toggle();
      for (int k = 0; k < 16; k++) begin
         in_valid    = (k % 2 == 0);
         in_row_data = 64'hA0 + 64'(k);
         tick();
         checks++;
         if (buf_data_enable !== (k % 2 == 0) || buf_matrix_row !== 8'(k / 2)) begin
            failures++;
            $display("FAIL toggle_k%0d en=%b row=%0d required %b %0d",
                     k, buf_data_enable, buf_matrix_row, k % 2 == 0, k / 2);
         end
      end
      in_valid = 1'b0;
      wait_out_valid();
      consume();
   endtask

   task automatic test_stall();
      send_block(64'hB0);
      wait_out_valid();
      send_block(64'hC0);
      for (int c = 0; c < 12; c++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || buf_zigzag_enable !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold_%0d out_valid=%b in_ready=%b zz=%b required 1 0 0",
                     c, out_valid, in_ready, buf_zigzag_enable);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_blk++;
      checks++;
      if (out_valid !== 1'b0 || blk_count !== exp_blk || in_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL stall_release out_valid=%b blk=%0d in_ready=%b busy=%b required 0 %0d 0 1",
                  out_valid, blk_count, in_ready, busy, exp_blk);
      end
      tick();
      tick();
      checks++;
      if (buf_zigzag_enable !== 1'b1) begin
         failures++;
         $display("FAIL stall_zigzag zz=%b required 1", buf_zigzag_enable);
      end
      wait_out_valid();
      consume();
   endtask

   task automatic test_simultaneous();
      send_block(64'hD0);
      wait_out_valid();
      for (int r = 0; r < 7; r++) send_row(64'hE0 + 64'(r), 8'(r));
      in_valid    = 1'b1;
      in_row_data = 64'hE7;
      out_ready   = 1'b1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL simul_pre in_ready=%b out_valid=%b required 1 1", in_ready, out_valid);
      end
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      exp_blk++;
      checks++;
      if (buf_data_enable !== 1'b1 || buf_matrix_row !== 8'd7 || buf_row_data !== 64'hE7 ||
          out_valid !== 1'b0 || blk_count !== exp_blk) begin
         failures++;
         $display("FAIL simul_edge en=%b row=%0d data=%h out_valid=%b blk=%0d required 1 7 e7 0 %0d",
                  buf_data_enable, buf_matrix_row, buf_row_data, out_valid, blk_count, exp_blk);
      end
      tick();
      tick();
      checks++;
      if (buf_zigzag_enable !== 1'b1 || blk_count !== exp_blk) begin
         failures++;
         $display("FAIL simul_zigzag zz=%b blk=%0d required 1 %0d",
                  buf_zigzag_enable, blk_count, exp_blk);
      end
      wait_out_valid();
      consume();
   endtask

   task automatic test_reset_mid();
      for (int r = 0; r < 5; r++) send_row(64'hF0 + 64'(r), 8'(r));
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_reset_values("reset_mid");
      exp_blk = 16'd0;
      send_block(64'h100);
      wait_out_valid();
      consume();
   endtask

   // in_valid and out_ready tied high: steady-state block period is
   // 8 + 3 + ZZ_LATENCY - 1 = 13 cycles; the 3-bit counter must wrap 7 -> 0.
   task automatic test_throughput_wrap();
      int          hs;
      int          last;
      bit          wrap_seen;
      bit          was_hs;
      logic [2:0]  old_w;
      logic [2:0]  exp_w;
      hs        = 0;
      last      = 0;
      wrap_seen = 1'b0;
      checks++;
      if (w_blk_count !== exp_blk[2:0]) begin
         failures++;
         $display("FAIL wrap_start w_blk=%0d required %0d", w_blk_count, exp_blk[2:0]);
      end
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 300 && hs < 9; cyc++) begin
         in_row_data = 64'(cyc);
         was_hs      = (out_valid === 1'b1);
         old_w       = w_blk_count;
         if (was_hs) begin
            hs++;
            if (hs >= 2) begin
               checks++;
               if (cyc - last != 13) begin
                  failures++;
                  $display("FAIL block_period got=%0d required=13", cyc - last);
               end
            end
            last = cyc;
         end
         tick();
         if (was_hs) begin
            exp_blk++;
            exp_w = old_w + 3'd1;
            if (old_w == 3'd7) wrap_seen = 1'b1;
            checks++;
            if (w_blk_count !== exp_w || blk_count !== exp_blk) begin
               failures++;
               $display("FAIL count_step w_blk=%0d blk=%0d required %0d %0d",
                        w_blk_count, blk_count, exp_w, exp_blk);
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (hs < 9 || !wrap_seen) begin
         failures++;
         $display("FAIL wrap_run handshakes=%0d wrap_seen=%b required 9 1", hs, wrap_seen);
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_single_block();
      test_toggle();
      test_stall();
      test_simultaneous();
      test_reset_mid();
      test_throughput_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
